// File: rtl/if_pkg.sv
// ============================================================================
// if_pkg : shared types and constants for the instruction-fetch stage
// Revision : 1.0
// ============================================================================
`default_nettype none

package if_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_REQ_KILL = 3'd2,
    ST_WAIT     = 3'd3,
    ST_DROP     = 3'd4,
    ST_FULL     = 3'd5
  } if_state_e;

  localparam logic [31:0] INST_NOP = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'd3;
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_skid_buf.sv
// ============================================================================
// if_skid_buf : one-entry {pc, inst} holding register absorbing decode stalls
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_skid_buf
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        unload_i,
  input  logic        clear_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic        valid_o,
  output logic        valid_d_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, inst_q;

  // Clear beats load beats unload; a simultaneous load+unload keeps the entry full.
  always_comb begin
    valid_d = valid_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
    end else if (unload_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= 32'h0;
      inst_q  <= INST_NOP;
    end else begin
      valid_q <= valid_d;
      if (load_i && !clear_i) begin
        pc_q   <= pc_i;
        inst_q <= inst_i;
      end
    end
  end

  assign valid_o   = valid_q;
  assign valid_d_o = valid_d;
  assign pc_o      = pc_q;
  assign inst_o    = inst_q;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// if_stage : MIPS fetch stage - PC, single-outstanding imem handshake, IF/ID reg
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_inst_q, out_inst_d;

  logic        consume, out_free, resp_take;
  logic        skid_load, skid_unload, skid_valid, skid_valid_d;
  logic [31:0] skid_pc, skid_inst, redirect_pc;

  assign redirect_pc = align_pc(redirect_pc_i);
  assign consume     = out_valid_q && !stall_i;
  assign out_free    = !out_valid_q || consume;
  // addr_q still holds the address of the in-flight request while in WAIT.
  assign resp_take   = (state_q == ST_WAIT) && imem_rvalid_i && !flush_i;
  assign skid_unload = out_free && skid_valid;
  assign skid_load   = resp_take && (!out_free || skid_valid);

  if_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (skid_load),
    .unload_i  (skid_unload),
    .clear_i   (flush_i),
    .pc_i      (addr_q),
    .inst_i    (imem_rdata_i),
    .valid_o   (skid_valid),
    .valid_d_o (skid_valid_d),
    .pc_o      (skid_pc),
    .inst_o    (skid_inst)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_valid_d = 1'b1;
        out_pc_d    = skid_pc;
        out_inst_d  = skid_inst;
      end else if (resp_take) begin
        out_valid_d = 1'b1;
        out_pc_d    = addr_q;
        out_inst_d  = imem_rdata_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    if (flush_i) begin
      pc_d = redirect_pc;
    end
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (flush_i) begin
          state_d = imem_gnt_i ? ST_DROP : ST_REQ_KILL;
        end else if (imem_gnt_i) begin
          pc_d    = pc_q + PC_STEP;
          state_d = ST_WAIT;
        end
      end
      ST_REQ_KILL: begin
        if (imem_gnt_i) begin
          state_d = ST_DROP;
        end
      end
      ST_WAIT: begin
        if (flush_i) begin
          state_d = imem_rvalid_i ? ST_REQ : ST_DROP;
        end else if (imem_rvalid_i) begin
          state_d = skid_valid_d ? ST_FULL : ST_REQ;
        end
      end
      ST_DROP: begin
        if (imem_rvalid_i) begin
          state_d = ST_REQ;
        end
      end
      ST_FULL: begin
        if (flush_i || !skid_valid_d) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // The request address is captured on entry to REQ so it stays frozen through REQ_KILL.
    if (state_d == ST_REQ) begin
      addr_d = pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      out_valid_q <= 1'b0;
      out_pc_q    <= 32'h0;
      out_inst_q  <= INST_NOP;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
    end
  end

  assign imem_req_o   = (state_q == ST_REQ) || (state_q == ST_REQ_KILL);
  assign imem_addr_o  = addr_q;
  assign pc_o         = out_pc_q;
  assign inst_o       = out_inst_q;
  assign inst_valid_o = out_valid_q;

`ifndef SYNTHESIS
  a_rvalid_only_when_waiting: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid_i |-> (state_q == ST_WAIT || state_q == ST_DROP));
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// tb_if_stage : randomized and directed bench for if_stage against a stream model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_pc_i (redirect_pc_i),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .inst_valid_o  (inst_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Memory model configuration and manual override (used while the model is off).
  bit          mem_en      = 1'b0;
  int          cfg_gnt_min = 0;
  int          cfg_gnt_max = 0;
  int          cfg_k_min   = 1;
  int          cfg_k_max   = 1;
  bit          man_rvalid  = 1'b0;
  logic [31:0] man_data    = 32'h0;

  // Reference model state: next PC decode must see, and request-stability tracking.
  logic [31:0] exp_pc    = RESET_PC;
  int          consumed  = 0;
  bit          hold_req  = 1'b0;
  logic [31:0] hold_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h3421_0001;
  endfunction

  bit          m_pending = 1'b0;
  int          m_lat     = 0;
  int          m_gcnt    = 0;
  logic [31:0] m_addr    = 32'h0;

  initial begin : mem_responder
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    forever begin
      @(negedge clk);
      if (!mem_en) begin
        m_pending     = 1'b0;
        m_gcnt        = $urandom_range(cfg_gnt_max, cfg_gnt_min);
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = man_rvalid;
        imem_rdata_i  = man_data;
      end else begin
        if (imem_rvalid_i) m_pending = 1'b0;
        if (imem_gnt_i) begin
          m_pending = 1'b1;
          m_lat     = $urandom_range(cfg_k_max, cfg_k_min);
          m_gcnt    = $urandom_range(cfg_gnt_max, cfg_gnt_min);
        end
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        if (m_pending) begin
          if (m_lat <= 1) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(m_addr);
          end else begin
            m_lat--;
          end
        end
        if (imem_req_o) begin
          if (m_gcnt == 0) begin
            imem_gnt_i = 1'b1;
            m_addr     = imem_addr_o;
          end else begin
            m_gcnt--;
          end
        end
      end
    end
  end

  // One clock cycle: drive decode-side inputs, then check the stream against the model.
  task automatic cycle(input bit stall, input bit flush, input logic [31:0] tgt);
    @(negedge clk);
    #1;
    stall_i       = stall;
    flush_i       = flush;
    redirect_pc_i = tgt;
    #2;
    if (rst_n) begin
      if (hold_req) begin
        vectors++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== hold_addr) begin
          miscompares++;
          $display("FAIL req_stable: req=%b addr=%h, expected req=1 addr=%h",
                   imem_req_o, imem_addr_o, hold_addr);
        end
      end
      hold_req  = imem_req_o && !imem_gnt_i;
      hold_addr = imem_addr_o;
      if (inst_valid_o && !stall && !flush) begin
        vectors++;
        if (pc_o !== exp_pc || inst_o !== mem_word(exp_pc)) begin
          miscompares++;
          $display("FAIL stream: pc=%h inst=%h, expected pc=%h inst=%h",
                   pc_o, inst_o, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (flush) exp_pc = tgt & ~32'd3;
    end
  endtask

  task automatic set_mem(input int gmin, input int gmax, input int kmin, input int kmax);
    cfg_gnt_min = gmin;
    cfg_gnt_max = gmax;
    cfg_k_min   = kmin;
    cfg_k_max   = kmax;
  endtask

  task automatic test_reset;
    rst_n         = 1'b0;
    stall_i       = 1'b0;
    flush_i       = 1'b0;
    redirect_pc_i = 32'h0;
    set_mem(0, 0, 1, 1);
    repeat (3) @(negedge clk);
    #3;
    vectors++;
    if (imem_req_o !== 1'b0 || imem_addr_o !== RESET_PC || inst_valid_o !== 1'b0 ||
        pc_o !== 32'h0 || inst_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_values: req=%b addr=%h valid=%b pc=%h inst=%h, expected 0/%h/0/0/0",
               imem_req_o, imem_addr_o, inst_valid_o, pc_o, inst_o, RESET_PC);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    mem_en = 1'b1;
    exp_pc = RESET_PC;
    #3;
    vectors++;
    if (imem_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_cycle: req=%b, expected 0", imem_req_o);
    end
  endtask

  task automatic test_first_fetch;
    cycle(1'b0, 1'b0, 32'h0);
    vectors++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC) begin
      miscompares++;
      $display("FAIL first_req: req=%b addr=%h, expected 1/%h", imem_req_o, imem_addr_o, RESET_PC);
    end
    cycle(1'b0, 1'b0, 32'h0);
    vectors++;
    if (inst_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_early: valid=%b, expected 0", inst_valid_o);
    end
    cycle(1'b0, 1'b0, 32'h0);
    vectors++;
    if (inst_valid_o !== 1'b1 || pc_o !== 32'h0 || inst_o !== 32'h3421_0001) begin
      miscompares++;
      $display("FAIL first_inst: valid=%b pc=%h inst=%h, expected 1/00000000/34210001",
               inst_valid_o, pc_o, inst_o);
    end
    vectors++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin
      miscompares++;
      $display("FAIL second_req: req=%b addr=%h, expected 1/00000004", imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_stall;
    int n;
    n = 0;
    while (exp_pc != 32'h8 && n < 50) begin
      cycle(1'b0, 1'b0, 32'h0);
      n++;
    end
    repeat (5) cycle(1'b1, 1'b0, 32'h0);
    vectors++;
    if (inst_valid_o !== 1'b1 || pc_o !== 32'h8 || imem_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_hold: valid=%b pc=%h req=%b, expected 1/00000008/0",
               inst_valid_o, pc_o, imem_req_o);
    end
    n = 0;
    while (exp_pc != 32'h10 && n < 20) begin
      cycle(1'b0, 1'b0, 32'h0);
      n++;
    end
    vectors++;
    if (exp_pc != 32'h10) begin
      miscompares++;
      $display("FAIL stall_drain: next expected pc=%h, expected 00000010", exp_pc);
    end
  endtask

  task automatic test_flush_wait;
    int n;
    set_mem(0, 0, 3, 3);
    n = 0;
    do begin
      cycle(1'b0, 1'b0, 32'h0);
      n++;
    end while (!(imem_req_o && imem_gnt_i) && n < 40);
    cycle(1'b0, 1'b1, 32'h0000_0103);
    n = 0;
    do begin
      cycle(1'b0, 1'b0, 32'h0);
      n++;
    end while (!imem_req_o && n < 20);
    vectors++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
      miscompares++;
      $display("FAIL flush_wait_req: req=%b addr=%h, expected 1/00000100", imem_req_o, imem_addr_o);
    end
    n = 0;
    while (exp_pc != 32'h108 && n < 40) begin
      cycle(1'b0, 1'b0, 32'h0);
      n++;
    end
    vectors++;
    if (exp_pc != 32'h108) begin
      miscompares++;
      $display("FAIL flush_wait_stream: next expected pc=%h, expected 00000108", exp_pc);
    end
  endtask

  task automatic test_flush_req;
    int          n;
    bit          prev;
    bit          found;
    logic [31:0] old;
    set_mem(3, 3, 1, 1);
    prev  = imem_req_o;
    found = 1'b0;
    n     = 0;
    while (!found && n < 60) begin
      cycle(1'b0, 1'b0, 32'h0);
      n++;
      if (imem_req_o && !imem_gnt_i && !prev) found = 1'b1;
      prev = imem_req_o;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL flush_req_setup: no fresh request seen, expected one within 60 cycles");
    end
    old = imem_addr_o;
    cycle(1'b0, 1'b1, 32'h0000_0200);
    n = 0;
    while (!imem_gnt_i && n < 10) begin
      cycle(1'b0, 1'b0, 32'h0);
      n++;
      vectors++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== old) begin
        miscompares++;
        $display("FAIL flush_req_hold: req=%b addr=%h, expected 1/%h", imem_req_o, imem_addr_o, old);
      end
    end
    n = 0;
    do begin
      cycle(1'b0, 1'b0, 32'h0);
      n++;
    end while (!imem_req_o && n < 10);
    vectors++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
      miscompares++;
      $display("FAIL flush_req_target: req=%b addr=%h, expected 1/00000200", imem_req_o, imem_addr_o);
    end
    n = 0;
    while (exp_pc != 32'h208 && n < 60) begin
      cycle(1'b0, 1'b0, 32'h0);
      n++;
    end
    vectors++;
    if (exp_pc != 32'h208) begin
      miscompares++;
      $display("FAIL flush_req_stream: next expected pc=%h, expected 00000208", exp_pc);
    end
    set_mem(0, 0, 1, 1);
  endtask

  task automatic test_wrap;
    int n;
    set_mem(0, 0, 1, 1);
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
    n = 0;
    do begin
      cycle(1'b0, 1'b0, 32'h0);
      n++;
    end while (!(imem_req_o && imem_gnt_i && imem_addr_o == 32'hFFFF_FFFC) && n < 20);
    n = 0;
    do begin
      cycle(1'b0, 1'b0, 32'h0);
      n++;
    end while (!imem_req_o && n < 10);
    vectors++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_req: req=%b addr=%h, expected 1/00000000", imem_req_o, imem_addr_o);
    end
    n = 0;
    while (exp_pc != 32'h4 && n < 20) begin
      cycle(1'b0, 1'b0, 32'h0);
      n++;
    end
    vectors++;
    if (exp_pc != 32'h4) begin
      miscompares++;
      $display("FAIL wrap_stream: next expected pc=%h, expected 00000004", exp_pc);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    set_mem(0, 0, 4, 4);
    n = 0;
    do begin
      cycle(1'b0, 1'b0, 32'h0);
      n++;
    end while (!(imem_req_o && imem_gnt_i) && n < 40);
    @(negedge clk);
    #1;
    mem_en     = 1'b0;
    man_data   = 32'hDEAD_BEEF;
    rst_n      = 1'b0;
    #1;
    vectors++;
    if (imem_req_o !== 1'b0 || imem_addr_o !== RESET_PC || inst_valid_o !== 1'b0 ||
        pc_o !== 32'h0 || inst_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid: req=%b addr=%h valid=%b pc=%h inst=%h, expected 0/%h/0/0/0",
               imem_req_o, imem_addr_o, inst_valid_o, pc_o, inst_o, RESET_PC);
    end
    man_rvalid = 1'b1;
    repeat (2) @(negedge clk);
    man_rvalid = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    exp_pc   = RESET_PC;
    hold_req = 1'b0;
    set_mem(0, 0, 1, 1);
    mem_en   = 1'b1;
    n = 0;
    while (exp_pc != 32'h10 && n < 40) begin
      cycle(1'b0, 1'b0, 32'h0);
      n++;
      if (inst_valid_o && inst_o == 32'hDEAD_BEEF) begin
        vectors++;
        miscompares++;
        $display("FAIL stray_data: inst=%h presented, expected never DEADBEEF", inst_o);
      end
    end
    vectors++;
    if (exp_pc != 32'h10) begin
      miscompares++;
      $display("FAIL reset_mid_stream: next expected pc=%h, expected 00000010", exp_pc);
    end
  endtask

  task automatic test_random;
    int start;
    start = consumed;
    set_mem(0, 2, 1, 3);
    for (int i = 0; i < 2500; i++) begin
      cycle(($urandom % 100) < 30, ($urandom % 100) < 3, $urandom);
    end
    repeat (10) cycle(1'b0, 1'b0, 32'h0);
    vectors++;
    if (consumed - start < 200) begin
      miscompares++;
      $display("FAIL random_progress: consumed=%0d, expected at least 200", consumed - start);
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    test_reset;
    test_first_fetch;
    test_stall;
    test_flush_wait;
    test_flush_req;
    test_wrap;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
